// File: rtl/enum_code_pkg.sv
// Shared types for the raw-code to Colors decoder slice.
// Colors enum, decoder FSM states and the legal code limit.
package enum_code_pkg;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } Colors;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } dec_state_e;

    localparam logic [1:0] CODE_MAX = 2'd2;

endpackage

// File: rtl/enum_code_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// A clear and an increment in the same cycle leave the count at 1.
module enum_code_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/enum_code_decoder.sv
// Range-checks raw 2-bit codes and casts legal ones to Colors.
// ENUM_CODE_DECODER_STATS_EN builds the err_cnt saturating counter.
module enum_code_decoder
    import enum_code_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_code,
    input  logic             strict,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output Colors            out_color,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fault
);

    dec_state_e state;
    logic       acc;
    logic       legal;
    logic       bad;

    // Gated by rst_n so nothing is offered while reset is held.
    assign in_ready = rst_n && (state == RUN) && (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;
    assign legal    = acc && (in_code <= CODE_MAX);
    assign bad      = acc && (in_code > CODE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_color <= RED;
        end else if (legal) begin
            out_valid <= 1'b1;
            out_color <= Colors'(in_code);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            fault <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (bad && strict) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end
                end
                FAULT: begin
                    if (clear) begin
                        state <= RUN;
                        fault <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (bad) begin
            err_sticky <= 1'b1;
        end else if (clear) begin
            err_sticky <= 1'b0;
        end
    end

`ifdef ENUM_CODE_DECODER_STATS_EN
    enum_code_sat_cnt #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clear),
        .inc  (bad),
        .cnt  (err_cnt)
    );
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_enum_code_decoder.sv
// Bench for enum_code_decoder: directed scenarios plus random traffic
// checked against a behavioural model of the decoder.
module tb_enum_code_decoder;
    import enum_code_pkg::*;

    localparam int CNT_W = 2;
    localparam int CMAX  = 3;
`ifdef ENUM_CODE_DECODER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_code;
    logic             strict;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    Colors            out_color;
    logic             err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic             fault;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    bit m_valid;
    int m_color;
    bit m_sticky;
    int m_cnt;
    bit m_fault;

    enum_code_decoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .strict    (strict),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_color (out_color),
        .err_sticky(err_sticky),
        .err_cnt   (err_cnt),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int ecnt(input int n);
        return STATS ? n : 0;
    endfunction

    function automatic bit m_rdy();
        return !m_fault && (!m_valid || out_ready);
    endfunction

    function automatic logic [6:0] exp_vec();
        return {m_valid, 2'(m_color), m_sticky, 2'(ecnt(m_cnt)), m_fault};
    endfunction

    wire [6:0] obs_vec = {out_valid, out_color, err_sticky, err_cnt, fault};

    task automatic model_reset();
        m_valid  = 0;
        m_color  = 0;
        m_sticky = 0;
        m_cnt    = 0;
        m_fault  = 0;
    endtask

    // One clock; the model applies clear first, then the accepted code.
    task automatic tick();
        bit acc;
        int code;
        acc  = in_valid && m_rdy();
        code = int'(in_code);
        @(posedge clk);
        if (clear) begin
            m_sticky = 0;
            m_cnt    = 0;
            m_fault  = 0;
        end
        if (acc && code <= 2) begin
            m_valid = 1;
            m_color = code;
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (acc && code == 3) begin
            m_sticky = 1;
            if (m_cnt < CMAX) m_cnt++;
            if (strict) m_fault = 1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 0;
        in_code   = 0;
        strict    = 0;
        clear     = 0;
        out_ready = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        in_valid = 1;
        rst_n    = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (obs_vec !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs_vec, 7'd0);
        end
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        in_valid = 0;
        rst_n    = 1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_legal();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            in_valid = 1;
            in_code  = 2'(c);
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL legal_ready code %0d: got %b want 1", c, in_ready);
            end
            tick();
            n_tests++;
            if ({out_valid, out_color} !== {1'b1, 2'(c)}) begin
                n_fail++;
                $display("FAIL legal_out code %0d: got v=%b c=%0d want v=1 c=%0d",
                         c, out_valid, out_color, c);
            end
        end
        in_valid = 0;
        tick();
        n_tests++;
        if ({out_valid, err_cnt, err_sticky} !== 4'b0) begin
            n_fail++;
            $display("FAIL legal_drain: got v=%b cnt=%0d sticky=%b want 0/0/0",
                     out_valid, err_cnt, err_sticky);
        end
    endtask

    task automatic test_invalid_nonstrict();
        int codes[3] = '{1, 3, 2};
        idle_inputs();
        foreach (codes[i]) begin
            in_valid = 1;
            in_code  = 2'(codes[i]);
            tick();
            n_tests++;
            if (out_valid !== (codes[i] != 3) || fault !== 1'b0 ||
                (codes[i] != 3 && out_color !== 2'(codes[i]))) begin
                n_fail++;
                $display("FAIL nonstrict code %0d: got v=%b c=%0d f=%b",
                         codes[i], out_valid, out_color, fault);
            end
        end
        in_valid = 0;
        tick();
        n_tests++;
        if (err_sticky !== 1'b1 || err_cnt !== 2'(ecnt(1)) || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL nonstrict_err: got sticky=%b cnt=%0d f=%b want 1/%0d/0",
                     err_sticky, err_cnt, fault, ecnt(1));
        end
    endtask

    task automatic test_strict();
        idle_inputs();
        strict   = 1;
        in_valid = 1;
        in_code  = 3;
        tick();
        n_tests++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL strict_fault: got %b want 1", fault);
        end
        strict = 0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (in_ready !== 1'b0 || fault !== 1'b1) begin
                n_fail++;
                $display("FAIL strict_hold %0d: got rdy=%b f=%b want 0/1",
                         i, in_ready, fault);
            end
            tick();
        end
        in_valid = 0;
        clear    = 1;
        tick();
        clear = 0;
        #1;
        n_tests++;
        if ({fault, err_sticky, err_cnt, in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL strict_clear: got f=%b sticky=%b cnt=%0d rdy=%b",
                     fault, err_sticky, err_cnt, in_ready);
        end
        in_valid = 1;
        in_code  = 0;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_color !== RED) begin
            n_fail++;
            $display("FAIL strict_after: got v=%b c=%0d want 1/RED",
                     out_valid, out_color);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_backpressure();
        idle_inputs();
        in_valid = 1;
        in_code  = 1;
        tick();
        out_ready = 0;
        in_code   = 2;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_color !== GREEN) begin
                n_fail++;
                $display("FAIL bp_hold %0d: got rdy=%b v=%b c=%0d want 0/1/GREEN",
                         i, in_ready, out_valid, out_color);
            end
            tick();
        end
        out_ready = 1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_color !== BLUE) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b c=%0d want 1/BLUE", out_valid, out_color);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_saturation();
        idle_inputs();
        clear = 1;
        tick();
        clear    = 0;
        in_valid = 1;
        in_code  = 3;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_tests++;
            if (err_cnt !== 2'(ecnt(i < CMAX ? i : CMAX)) || err_sticky !== 1'b1) begin
                n_fail++;
                $display("FAIL sat step %0d: got cnt=%0d sticky=%b want %0d/1",
                         i, err_cnt, err_sticky, ecnt(i < CMAX ? i : CMAX));
            end
        end
        clear = 1;
        tick();
        n_tests++;
        if (err_cnt !== 2'(ecnt(1)) || err_sticky !== 1'b1 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_collide: got cnt=%0d sticky=%b f=%b want %0d/1/0",
                     err_cnt, err_sticky, fault, ecnt(1));
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_code   = 2'($urandom);
            strict    = ($urandom % 8) == 0;
            clear     = ($urandom % 16) == 0;
            out_ready = ($urandom % 3) != 0;
            #1;
            n_tests++;
            if (in_ready !== m_rdy()) begin
                n_fail++;
                $display("FAIL rand_ready cyc %0d: got %b want %b", i, in_ready, m_rdy());
            end
            tick();
            n_tests++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_state cyc %0d: got %b want %b", i, obs_vec, exp_vec());
            end
        end
        idle_inputs();
        clear = 1;
        tick();
        clear = 0;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        out_ready = 0;
        in_valid  = 1;
        in_code   = 2;
        tick();
        in_valid = 0;
        n_tests++;
        if (out_valid !== 1'b1 || out_color !== BLUE) begin
            n_fail++;
            $display("FAIL mid_load: got v=%b c=%0d want 1/BLUE", out_valid, out_color);
        end
        #2;
        rst_n = 0;
        model_reset();
        #1;
        n_tests++;
        if (obs_vec !== 7'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got %b rdy=%b want 0000000 rdy=0", obs_vec, in_ready);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_legal();
        test_invalid_nonstrict();
        test_strict();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
